// File: rtl/ddr_rw_arbiter.sv
// Single-port scheduler sharing the DDR burst controller between a write and a read client.
// Grants one burst at a time, with read urgency, an anti-starvation streak limit and a watchdog.
module ddr_rw_arbiter #(
  parameter int unsigned ADDR_W        = 25,
  parameter int unsigned LEN_W         = 10,
  parameter int unsigned TIMEOUT_CYC   = 4096,
  parameter int unsigned MAX_RD_STREAK = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic              ddr_clk,
  input  logic              ddr_rst,
  input  logic              ddr_ready,
  input  logic              mem_wen,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LEN_W-1:0]  wr_len,
  output logic              mem_wen_valid,
  input  logic              mem_ren,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [LEN_W-1:0]  rd_len,
  output logic              mem_ren_valid,
  input  logic              rd_urgent,
  output logic              wr_burst_req,
  output logic [ADDR_W-1:0] wr_burst_addr,
  output logic [LEN_W-1:0]  wr_burst_len,
  input  logic              wr_burst_finish,
  output logic              rd_burst_req,
  output logic [ADDR_W-1:0] rd_burst_addr,
  output logic [LEN_W-1:0]  rd_burst_len,
  input  logic              rd_burst_finish,
  output logic              arb_busy,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  wr_burst_cnt,
  output logic [CNT_W-1:0]  rd_burst_cnt
);

  localparam int unsigned WDOG_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned STRK_W = $clog2(MAX_RD_STREAK + 1);
  localparam logic [WDOG_W-1:0] WdogMax   = WDOG_W'(TIMEOUT_CYC - 1);
  localparam logic [STRK_W-1:0] StreakMax = STRK_W'(MAX_RD_STREAK);

  typedef enum logic [1:0] {StIdle, StWrBusy, StRdBusy} state_e;

  state_e              state_q, state_d;
  logic                last_rd_q, last_rd_d;
  logic [STRK_W-1:0]   streak_q, streak_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic                wen_valid_q, wen_valid_d;
  logic                ren_valid_q, ren_valid_d;
  logic                wr_req_q, wr_req_d;
  logic                rd_req_q, rd_req_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [LEN_W-1:0]    wr_len_q, wr_len_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [LEN_W-1:0]    rd_len_q, rd_len_d;
  logic                timeout_q, timeout_d;
  logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic                grant_wr, grant_rd;

  always_comb begin
    state_d     = state_q;
    last_rd_d   = last_rd_q;
    streak_d    = streak_q;
    wdog_d      = wdog_q;
    wen_valid_d = 1'b0;
    ren_valid_d = 1'b0;
    wr_req_d    = wr_req_q;
    rd_req_d    = rd_req_q;
    wr_addr_d   = wr_addr_q;
    wr_len_d    = wr_len_q;
    rd_addr_d   = rd_addr_q;
    rd_len_d    = rd_len_q;
    timeout_d   = timeout_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    grant_wr    = 1'b0;
    grant_rd    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Hold off while an ack is still out so the client can drop its level request.
        if (ddr_ready && !wen_valid_q && !ren_valid_q) begin
          if (mem_wen && mem_ren) begin
            if (rd_urgent) begin
              if (streak_q < StreakMax) grant_rd = 1'b1;
              else                      grant_wr = 1'b1;
            end else if (last_rd_q) begin
              grant_wr = 1'b1;
            end else begin
              grant_rd = 1'b1;
            end
          end else if (mem_wen) begin
            grant_wr = 1'b1;
          end else if (mem_ren) begin
            grant_rd = 1'b1;
          end
        end

        if (grant_wr) begin
          wen_valid_d = 1'b1;
          last_rd_d   = 1'b0;
          streak_d    = '0;
          wdog_d      = '0;
          if (wr_len != '0) begin
            wr_req_d  = 1'b1;
            wr_addr_d = wr_addr;
            wr_len_d  = wr_len;
            state_d   = StWrBusy;
          end
        end

        if (grant_rd) begin
          ren_valid_d = 1'b1;
          last_rd_d   = 1'b1;
          wdog_d      = '0;
          if (!mem_wen)       streak_d = '0;
          else if (rd_urgent) streak_d = streak_q + STRK_W'(1);
          if (rd_len != '0) begin
            rd_req_d  = 1'b1;
            rd_addr_d = rd_addr;
            rd_len_d  = rd_len;
            state_d   = StRdBusy;
          end
        end
      end

      // While the controller is not ready the burst is frozen; only the watchdog may end it.
      StWrBusy: begin
        if (ddr_ready && wr_burst_finish) begin
          wr_req_d = 1'b0;
          wr_cnt_d = wr_cnt_q + CNT_W'(1);
          state_d  = StIdle;
        end else if (wdog_q == WdogMax) begin
          wr_req_d  = 1'b0;
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end

      StRdBusy: begin
        if (ddr_ready && rd_burst_finish) begin
          rd_req_d = 1'b0;
          rd_cnt_d = rd_cnt_q + CNT_W'(1);
          state_d  = StIdle;
        end else if (wdog_q == WdogMax) begin
          rd_req_d  = 1'b0;
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ddr_clk) begin
    if (ddr_rst) begin
      state_q     <= StIdle;
      last_rd_q   <= 1'b1;
      streak_q    <= '0;
      wdog_q      <= '0;
      wen_valid_q <= 1'b0;
      ren_valid_q <= 1'b0;
      wr_req_q    <= 1'b0;
      rd_req_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_len_q    <= '0;
      rd_addr_q   <= '0;
      rd_len_q    <= '0;
      timeout_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_rd_q   <= last_rd_d;
      streak_q    <= streak_d;
      wdog_q      <= wdog_d;
      wen_valid_q <= wen_valid_d;
      ren_valid_q <= ren_valid_d;
      wr_req_q    <= wr_req_d;
      rd_req_q    <= rd_req_d;
      wr_addr_q   <= wr_addr_d;
      wr_len_q    <= wr_len_d;
      rd_addr_q   <= rd_addr_d;
      rd_len_q    <= rd_len_d;
      timeout_q   <= timeout_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
    end
  end

  assign mem_wen_valid = wen_valid_q;
  assign mem_ren_valid = ren_valid_q;
  assign wr_burst_req  = wr_req_q;
  assign wr_burst_addr = wr_addr_q;
  assign wr_burst_len  = wr_len_q;
  assign rd_burst_req  = rd_req_q;
  assign rd_burst_addr = rd_addr_q;
  assign rd_burst_len  = rd_len_q;
  assign arb_busy      = (state_q != StIdle);
  assign timeout_err   = timeout_q;
  assign wr_burst_cnt  = wr_cnt_q;
  assign rd_burst_cnt  = rd_cnt_q;

endmodule

// File: doc/ddr_rw_arbiter.md
Name: ddr_rw_arbiter

Overview:
Single-port scheduler that shares the DDR burst controller between the camera frame writer (write client) and the display-FIFO reader (read client). It accepts level requests with address and length from each client and grants one burst at a time. It returns the mem_wen_valid/mem_ren_valid acknowledges the clients already use. It drives the controller's burst request/finish handshake, supports read urgency with anti-starvation, and has a burst watchdog plus debug counters.

Parameters:
ADDR_W, 25, DDR burst address width
LEN_W, 10, burst length width (beats)
TIMEOUT_CYC, 4096, max cycles from grant to burst finish before abort
MAX_RD_STREAK, 4, max consecutive urgent read grants while a write is pending
CNT_W, 16, width of burst debug counters

Ports:
ddr_clk  in  1  DDR user clock; only clock
ddr_rst  in  1  synchronous active-high reset
ddr_ready  in  1  controller calibrated/idle-capable; no grant while low
mem_wen  in  1  write client request (level, held until mem_wen_valid)
wr_addr  in  ADDR_W  write burst start address
wr_len  in  LEN_W  write burst length
mem_wen_valid  out  1  one-cycle write grant/ack
mem_ren  in  1  read client request (level, held until mem_ren_valid)
rd_addr  in  ADDR_W  read burst start address
rd_len  in  LEN_W  read burst length
mem_ren_valid  out  1  one-cycle read grant/ack
rd_urgent  in  1  display FIFO low; read preferred
wr_burst_req  out  1  to controller, held until wr_burst_finish
wr_burst_addr  out  ADDR_W  latched write address
wr_burst_len  out  LEN_W  latched write length
wr_burst_finish  in  1  controller write-burst-done pulse
rd_burst_req  out  1  to controller, held until rd_burst_finish
rd_burst_addr  out  ADDR_W  latched read address
rd_burst_len  out  LEN_W  latched read length
rd_burst_finish  in  1  controller read-burst-done pulse
arb_busy  out  1  high in WR_BUSY/RD_BUSY
timeout_err  out  1  sticky watchdog flag
wr_burst_cnt  out  CNT_W  completed write bursts, wraps
rd_burst_cnt  out  CNT_W  completed read bursts, wraps

Behaviour:
- Reset (ddr_rst=1 at a ddr_clk edge): every output 0, state IDLE, last_grant=READ, streak=0, watchdog=0. Reset mid-burst abandons the burst; the controller is reset in the same domain.
- States: IDLE, WR_BUSY, RD_BUSY.
- IDLE, ddr_ready=1, selection:
  - Only one request high: grant it.
  - Both high, rd_urgent=1, streak<MAX_RD_STREAK: grant read and increment streak.
  - Both high, rd_urgent=1, streak=MAX_RD_STREAK: grant write.
  - Both high, rd_urgent=0: grant the client opposite last_grant.
  - streak clears on any write grant or when mem_wen=0 at a read grant.
- Grant edge (cycle 0):
  - mem_x_valid=1 for exactly one cycle.
  - x_burst_addr/len latched from the client inputs.
  - x_burst_req=1, state→X_BUSY, last_grant updated, watchdog cleared.
  - Grant latency: 1 edge after request is sampled in IDLE.
- Zero-length request (len=0): ack pulse issued; no burst_req; state stays IDLE; counters unchanged.
- X_BUSY:
  - Client requests ignored. Requests raised during BUSY are serviced after return to IDLE.
  - On the edge sampling x_burst_finish=1: x_burst_req→0, x_burst_cnt+1 (modulo 2^CNT_W), state→IDLE.
  - Earliest next grant is the following edge, so there is a minimum one idle cycle between bursts.
- Finish of the non-active channel, or any finish while IDLE: ignored.
- Watchdog: counts in BUSY. When it reaches TIMEOUT_CYC-1 without finish, the next edge drops burst_req, sets timeout_err=1 (cleared only by reset), returns to IDLE, and leaves the counter unchanged.
- ddr_ready low in BUSY: the burst is held; only the watchdog can end it. ddr_ready low in IDLE: no grants.
- Never both burst_req high; never both valid high.
- Latched addr/len hold stable while burst_req=1.

Test Plan:
- Single read: mem_ren=1, rd_addr=0x100, rd_len=256, finish after 300 cycles → mem_ren_valid one cycle after sampling, rd_burst_req high 300 cycles, rd_burst_addr=0x100, rd_burst_cnt=1.
- Contention, rd_urgent=0: both requests held continuously, finish 10 cycles after each grant → grants alternate W,R,W,R (first is write after reset), ≥1 idle cycle between bursts.
- Urgency starvation guard: both held, rd_urgent=1, MAX_RD_STREAK=4 → grant order R,R,R,R,W,R,R,R,R,W.
- Watchdog: TIMEOUT_CYC=16, grant write, withhold wr_burst_finish → wr_burst_req drops after 16 cycles, timeout_err=1 sticky, wr_burst_cnt=0, next request granted normally.
- Boundaries: wr_len=0 → ack only, no wr_burst_req. ddr_ready=0 with requests → no grant until ready=1. Stray rd_burst_finish in IDLE → no effect. ddr_rst asserted mid RD_BUSY → all outputs 0 the next edge.
- Counter wrap: CNT_W=4, 17 read bursts → rd_burst_cnt=1.
